// File: rtl/result_report_tx.sv
// Streams a 10-byte checksummed sweep-result frame into the uart register
// interface. TX-ready is polled before every byte and each poll has a timeout.
module result_report_tx #(
   parameter logic [7:0] HEADER        = 8'hA5,
   parameter logic [7:0] STATUS_ADDR   = 8'd1,
   parameter logic [7:0] DATA_ADDR     = 8'd2,
   parameter int         TX_READY_BIT  = 1,
   parameter int         SETTLE_CYCLES = 2,
   parameter int         POLL_TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        fail,
   input  logic        sw_valid,
   input  logic [15:0] phase_steps,
   input  logic [15:0] sw_score,
   input  logic [6:0]  sw_i,
   input  logic [6:0]  sw_j,
   input  logic [7:0]  uart_dout,
   output logic [7:0]  uart_addr,
   output logic [7:0]  uart_din,
   output logic        uart_w_en,
   output logic        uart_r_en,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int TO_W  = ($clog2(POLL_TIMEOUT + 1) > 20) ? $clog2(POLL_TIMEOUT + 1) : 20;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(POLL_TIMEOUT);
   localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       FRAME_LEN = 8'h07;
   localparam logic [3:0]       LAST_IDX  = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_POLL_REQ = 3'd1,
      ST_POLL_CHK = 3'd2,
      ST_WRITE    = 3'd3,
      ST_SETTLE   = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // XOR of the seven payload bytes; header and length are not covered.
   function automatic logic [7:0] payload_xor(input logic [55:0] p);
      logic [7:0] acc;
      acc = 8'h00;
      for (int b = 0; b < 7; b++) begin
         acc = acc ^ p[8*b +: 8];
      end
      return acc;
   endfunction

   function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                             input logic [55:0] p,
                                             input logic [7:0]  cs);
      logic [7:0] v;
      case (idx)
         4'd0:    v = HEADER;
         4'd1:    v = FRAME_LEN;
         4'd2:    v = p[55:48];
         4'd3:    v = p[47:40];
         4'd4:    v = p[39:32];
         4'd5:    v = p[31:24];
         4'd6:    v = p[23:16];
         4'd7:    v = p[15:8];
         4'd8:    v = p[7:0];
         4'd9:    v = cs;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   state_t            state_r, state_s;
   logic [3:0]        idx_r, idx_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_s, to_inc_s;
   logic [SET_W-1:0]  set_cnt_r, set_cnt_s;
   logic              err_r, err_s;
   logic              capture_s;
   logic [1:0]        rst_sync_r;
   logic              run_s;
   logic [55:0]       payload_r, payload_s;
   logic [7:0]        csum_r;
   logic [7:0]        uart_addr_r, uart_din_r;
   logic              uart_w_en_r, uart_r_en_r, busy_r, done_r;
   logic              unused_dout_s;

   assign unused_dout_s = ^uart_dout;
   assign run_s         = rst_sync_r[1];
   assign payload_s     = {6'b000000, sw_valid, fail, phase_steps, sw_score,
                           1'b0, sw_i, 1'b0, sw_j};
   assign to_inc_s      = (to_cnt_r == {TO_W{1'b1}}) ? to_cnt_r : to_cnt_r + TO_W'(1);

   // Reset release synchroniser; starts are refused until it has drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Next-state and per-byte bookkeeping.
   always_comb begin
      state_s   = state_r;
      idx_s     = idx_r;
      to_cnt_s  = to_cnt_r;
      set_cnt_s = set_cnt_r;
      err_s     = err_r;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && run_s) begin
               state_s   = ST_POLL_REQ;
               idx_s     = 4'd0;
               to_cnt_s  = {TO_W{1'b0}};
               err_s     = 1'b0;
               capture_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_POLL_REQ: begin
            state_s = ST_POLL_CHK;
         end
         ST_POLL_CHK: begin
            // Stay here while not ready: each failing cycle costs exactly one cycle.
            if (uart_dout[TX_READY_BIT]) begin
               state_s   = ST_WRITE;
               set_cnt_s = {SET_W{1'b0}};
            end else if (to_inc_s >= TO_LIMIT) begin
               to_cnt_s = to_inc_s;
               err_s    = 1'b1;
               state_s  = ST_DONE;
            end else begin
               to_cnt_s = to_inc_s;
            end
         end
         ST_WRITE: begin
            state_s   = ST_SETTLE;
            set_cnt_s = {SET_W{1'b0}};
         end
         ST_SETTLE: begin
            if (set_cnt_r == SET_LAST) begin
               if (idx_r == LAST_IDX) begin
                  state_s = ST_DONE;
               end else begin
                  idx_s    = idx_r + 4'd1;
                  to_cnt_s = {TO_W{1'b0}};
                  state_s  = ST_POLL_REQ;
               end
            end else begin
               set_cnt_s = set_cnt_r + SET_W'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         idx_r     <= 4'd0;
         to_cnt_r  <= {TO_W{1'b0}};
         set_cnt_r <= {SET_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         idx_r     <= idx_s;
         to_cnt_r  <= to_cnt_s;
         set_cnt_r <= set_cnt_s;
         err_r     <= err_s;
      end
   end

   // Frame capture: the whole frame is frozen when start is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         payload_r <= 56'd0;
         csum_r    <= 8'h00;
      end else if (capture_s) begin
         payload_r <= payload_s;
         csum_r    <= payload_xor(payload_s);
      end else begin
         payload_r <= payload_r;
         csum_r    <= csum_r;
      end
   end

   // Outputs are decoded from the next state so they line up with state_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uart_addr_r <= 8'h00;
         uart_din_r  <= 8'h00;
         uart_w_en_r <= 1'b0;
         uart_r_en_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         uart_w_en_r <= (state_s == ST_WRITE);
         uart_r_en_r <= (state_s == ST_POLL_REQ) || (state_s == ST_POLL_CHK);
         busy_r      <= (state_s == ST_POLL_REQ) || (state_s == ST_POLL_CHK) ||
                        (state_s == ST_WRITE)    || (state_s == ST_SETTLE);
         done_r      <= (state_s == ST_DONE);
         case (state_s)
            ST_POLL_REQ, ST_POLL_CHK: begin
               uart_addr_r <= STATUS_ADDR;
               uart_din_r  <= 8'h00;
            end
            ST_WRITE: begin
               uart_addr_r <= DATA_ADDR;
               uart_din_r  <= frame_byte(idx_s, payload_r, csum_r);
            end
            default: begin
               uart_addr_r <= 8'h00;
               uart_din_r  <= 8'h00;
            end
         endcase
      end
   end

   assign uart_addr = uart_addr_r;
   assign uart_din  = uart_din_r;
   assign uart_w_en = uart_w_en_r;
   assign uart_r_en = uart_r_en_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_result_report_tx.sv
// Randomised scoreboard bench for result_report_tx: a behavioural UART status
// model with programmable not-ready stretches, and a monitor checking frames and protocol.
module tb_result_report_tx;

   localparam int T_TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        fail = 1'b0;
   logic        sw_valid = 1'b0;
   logic [15:0] phase_steps = 16'h0000;
   logic [15:0] sw_score = 16'h0000;
   logic [6:0]  sw_i = 7'd0;
   logic [6:0]  sw_j = 7'd0;
   logic [7:0]  uart_dout = 8'h00;
   logic [7:0]  uart_addr, uart_din;
   logic        uart_w_en, uart_r_en, busy, done, err;

   result_report_tx #(.POLL_TIMEOUT(T_TO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .fail(fail), .sw_valid(sw_valid),
      .phase_steps(phase_steps), .sw_score(sw_score), .sw_i(sw_i), .sw_j(sw_j),
      .uart_dout(uart_dout), .uart_addr(uart_addr), .uart_din(uart_din),
      .uart_w_en(uart_w_en), .uart_r_en(uart_r_en), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] data; int at; } wr_t;
   typedef struct { int at; logic err; } dn_t;
   wr_t exp_wr[$];
   dn_t exp_dn[$];

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // UART status model: N not-ready reads before byte k, or stuck not-ready from byte k.
   int stall_cfg[10];
   int stuck_k = -1;
   int used[10];
   int wcnt = 0;
   logic [7:0] noise;
   always @(posedge clk) begin
      if (!rst_n) begin
         wcnt <= 0;
         for (int k = 0; k < 10; k++) used[k] <= 0;
      end else begin
         if (start && !busy && !done) begin
            wcnt <= 0;
            for (int k = 0; k < 10; k++) used[k] <= 0;
         end else if (uart_w_en) begin
            wcnt <= wcnt + 1;
         end
         if (uart_r_en && uart_addr == 8'd1) begin
            noise = 8'($urandom);
            if (stuck_k >= 0 && wcnt >= stuck_k) begin
               noise[1] = 1'b0;
            end else if (wcnt < 10 && used[wcnt] < stall_cfg[wcnt]) begin
               noise[1] = 1'b0;
               used[wcnt] <= used[wcnt] + 1;
            end else begin
               noise[1] = 1'b1;
            end
            uart_dout <= noise;
         end
      end
   end

   // Monitor: pops the scoreboard on every write/done and checks bus protocol.
   int   last_w = -100;
   logic prev_w = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;
   wr_t  mon_e;
   dn_t  mon_d;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_w = 1'b0; prev_rdy = 1'b0; prev_done = 1'b0; last_w = -100;
      end else begin
         check("rw_exclusive", {63'd0, uart_w_en & uart_r_en}, 64'd0);
         if (uart_w_en) begin
            check("w_addr", uart_addr, 64'd2);
            check("w_one_cycle", prev_w, 64'd0);
            check("w_settle_gap", (cyc - last_w) >= 3, 64'd1);
            check("w_after_ready", prev_rdy, 64'd1);
            check("wr_expected", exp_wr.size() > 0, 64'd1);
            if (exp_wr.size() > 0) begin
               mon_e = exp_wr.pop_front();
               check("wr_data", uart_din, mon_e.data);
               check("wr_cycle", cyc, mon_e.at);
            end
            last_w = cyc;
         end
         if (done) begin
            check("done_one_cycle", prev_done, 64'd0);
            check("done_busy_low", busy, 64'd0);
            check("done_expected", exp_dn.size() > 0, 64'd1);
            if (exp_dn.size() > 0) begin
               mon_d = exp_dn.pop_front();
               check("done_cycle", cyc, mon_d.at);
               check("done_err", err, mon_d.err);
            end
         end
         prev_w = uart_w_en;
         prev_rdy = uart_r_en & uart_dout[1];
         prev_done = done;
      end
   end

   // Reference: frame bytes and event times from the frame rules, then start pulse.
   task automatic issue(input logic f, input logic v, input logic [15:0] ph,
                        input logic [15:0] sc, input logic [6:0] i, input logic [6:0] j,
                        input int stuck, output int s);
      logic [7:0] b[10];
      int acc;
      b[0] = 8'hA5; b[1] = 8'h07; b[2] = {6'd0, v, f};
      b[3] = ph[15:8]; b[4] = ph[7:0]; b[5] = sc[15:8]; b[6] = sc[7:0];
      b[7] = {1'b0, i}; b[8] = {1'b0, j};
      b[9] = 8'h00;
      for (int k = 2; k <= 8; k++) b[9] = b[9] ^ b[k];
      s = cyc;
      acc = 0;
      stuck_k = stuck;
      for (int k = 0; k < 10; k++) begin
         if (stuck >= 0 && k >= stuck) break;
         acc += stall_cfg[k];
         exp_wr.push_back('{data: b[k], at: s + 3 + 5 * k + acc});
      end
      if (stuck >= 0) exp_dn.push_back('{at: s + 2 + 5 * stuck + acc + T_TO, err: 1'b1});
      else            exp_dn.push_back('{at: s + 51 + acc, err: 1'b0});
      fail = f; sw_valid = v; phase_steps = ph; sw_score = sc; sw_i = i; sw_j = j;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_rise", busy, 64'd1);
      check("err_clear_on_start", err, 64'd0);
   endtask

   task automatic wait_frame();
      int n;
      n = 0;
      while (exp_dn.size() > 0 && n < 4000) begin
         @(posedge clk);
         n++;
      end
      check("frame_end_seen", exp_dn.size(), 64'd0);
      check("all_writes_seen", exp_wr.size(), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      check("idle_busy", busy, 64'd0);
      check("idle_w_en", uart_w_en, 64'd0);
      check("idle_r_en", uart_r_en, 64'd0);
   endtask

   task automatic clear_stalls();
      for (int k = 0; k < 10; k++) stall_cfg[k] = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"}, uart_addr, 64'd0);
      check({tag, "_din"}, uart_din, 64'd0);
      check({tag, "_w_en"}, uart_w_en, 64'd0);
      check({tag, "_r_en"}, uart_r_en, 64'd0);
      check({tag, "_busy"}, busy, 64'd0);
      check({tag, "_done"}, done, 64'd0);
      check({tag, "_err"}, err, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int n;
      clear_stalls();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // Nominal frame: A5 07 01 01 23 00 05 03 02 27
      issue(1'b1, 1'b0, 16'h0123, 16'h0005, 7'd3, 7'd2, -1, s);
      wait_frame();
      check("nominal_err", err, 64'd0);

      // Backpressure: 10 not-ready cycles before byte 4
      stall_cfg[4] = 10;
      issue(1'b1, 1'b0, 16'h0123, 16'h0005, 7'd3, 7'd2, -1, s);
      wait_frame();
      clear_stalls();

      // Timeout: ready stuck low from byte 2
      issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            7'($urandom), 7'($urandom), 2, s);
      wait_frame();
      check("err_sticky", err, 64'd1);
      stuck_k = -1;
      issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            7'($urandom), 7'($urandom), -1, s);
      wait_frame();

      // Start while busy (with input changes) and start during DONE are ignored
      issue(1'b0, 1'b1, 16'($urandom), 16'($urandom), 7'($urandom), 7'($urandom), -1, s);
      repeat (9) @(posedge clk);
      #1;
      fail = ~fail; sw_valid = ~sw_valid;
      phase_steps = ~phase_steps; sw_score = sw_score + 16'd1;
      sw_i = ~sw_i; sw_j = ~sw_j;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_seen_busy_test", done, 64'd1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_frame();

      // Async reset during the byte 5 write
      issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            7'($urandom), 7'($urandom), -1, s);
      repeat (27) @(posedge clk);
      #2;
      check("pre_reset_write", uart_w_en, 64'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      exp_wr.delete();
      exp_dn.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            7'($urandom), 7'($urandom), -1, s);
      wait_frame();

      // Random frames with random not-ready stretches
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 10; k++) begin
            stall_cfg[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
         end
         issue(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               7'($urandom), 7'($urandom), -1, s);
         wait_frame();
         check("random_err", err, 64'd0);
      end
      clear_stalls();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
